// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the instruction fetch unit: FSM state
//                encoding and default values for the address width, the
//                instruction width and the reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned c_DEFAULT_AW       = 8;
    localparam int unsigned c_DEFAULT_IW       = 16;
    localparam int unsigned c_DEFAULT_RESET_PC = 0;

    // FETCH: a read request is outstanding at pc.
    // ISSUE: ibuf holds a word waiting to be handed downstream.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Instruction-memory read bus between the fetch unit and the
//                instruction memory.
//                  mem_req   - read request (fetch side drives)
//                  mem_addr  - read address (fetch side drives)
//                  mem_ack   - read data valid this cycle (memory drives)
//                  mem_rdata - instruction word (memory drives)
//                Modport master = fetch unit, slave = memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned AW = c_DEFAULT_AW,
    parameter int unsigned IW = c_DEFAULT_IW
);

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : AW-bit program counter. Synchronous reset to RESET_PC; a load
//                takes priority over an increment; the increment wraps modulo
//                2^AW.
//                  clk, reset    - clock, synchronous active-high reset
//                  i_load        - load i_load_addr on the next edge
//                  i_load_addr   - address to load
//                  i_inc         - increment on the next edge
//                  o_pc          - current PC
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned AW       = c_DEFAULT_AW,
    parameter int unsigned RESET_PC = c_DEFAULT_RESET_PC
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_load,
    input  wire logic [AW-1:0] i_load_addr,
    input  wire logic          i_inc,
    output logic      [AW-1:0] o_pc
);

    localparam logic [AW-1:0] c_RESET_PC = AW'(RESET_PC);
    localparam logic [AW-1:0] c_ONE      = AW'(1);

    logic [AW-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= c_RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + c_ONE;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Two-state instruction fetch unit. Requests a word at pc,
//                buffers it in ibuf, then issues it downstream with a one-cycle
//                ir_en pulse. Branches override acks and stalls; reset
//                overrides everything.
//                  clk, reset  - clock, synchronous active-high reset
//                  mem         - instruction memory read bus (master side)
//                  stall       - downstream cannot accept this cycle
//                  br_taken    - redirect request
//                  br_target   - redirect address
//                  ir_en       - one-cycle load enable for the IR
//                  ir_data     - buffered instruction (always ibuf)
//                  pc          - current fetch address
//                  icount      - issued-instruction count, wraps at 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned AW       = c_DEFAULT_AW,
    parameter int unsigned IW       = c_DEFAULT_IW,
    parameter int unsigned RESET_PC = c_DEFAULT_RESET_PC
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fetch_if.master            mem,
    input  wire logic          stall,
    input  wire logic          br_taken,
    input  wire logic [AW-1:0] br_target,
    output logic               ir_en,
    output logic      [IW-1:0] ir_data,
    output logic      [AW-1:0] pc,
    output logic      [15:0]   icount
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ibuf;
    logic [15:0]   r_icount;
    logic          w_mem_req;
    logic          w_ir_en;
    logic          w_fetch_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. A branch always returns to FETCH and blocks
    // both the fetch completion and the issue pulse. mem_ack is only looked
    // at in FETCH, so an ack arriving while no request is out is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_req    = 1'b0;
        w_ir_en      = 1'b0;
        w_fetch_done = 1'b0;

        case (r_state)
            FETCH: begin
                w_mem_req = 1'b1;
                if (br_taken) begin
                    w_state_nxt = FETCH;
                end else if (mem.mem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (br_taken) begin
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_ir_en     = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase

        // Reset gates the request and the issue pulse in the same cycle.
        if (reset) begin
            w_mem_req    = 1'b0;
            w_ir_en      = 1'b0;
            w_fetch_done = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer and issue counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ibuf   <= '0;
            r_icount <= '0;
        end else begin
            if (w_fetch_done) begin
                r_ibuf <= mem.mem_rdata;
            end
            if (w_ir_en) begin
                r_icount <= r_icount + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load      (br_taken),
        .i_load_addr (br_target),
        .i_inc       (w_fetch_done),
        .o_pc        (pc)
    );

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = pc;
    assign ir_en        = w_ir_en;
    assign ir_data      = r_ibuf;
    assign icount       = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking testbench for fetch_unit. Directed scenarios
//                plus a randomized run, all checked against a behavioural
//                model of the fetch/issue rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int unsigned AW       = 8;
    localparam int unsigned IW       = 16;
    localparam int unsigned RESET_PC = 0;

    logic          clk = 1'b0;
    logic          t_reset = 1'b1;
    logic          t_ack = 1'b0;
    logic [IW-1:0] t_rdata = '0;
    logic          t_stall = 1'b0;
    logic          t_br = 1'b0;
    logic [AW-1:0] t_tgt = '0;

    logic          ir_en;
    logic [IW-1:0] ir_data;
    logic [AW-1:0] pc;
    logic [15:0]   icount;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: "holding" means a fetched word waits to be issued.
    bit          m_holding;
    int          m_pc;
    logic [15:0] m_ibuf;
    int          m_cnt;

    fetch_if #(.AW(AW), .IW(IW)) mif ();

    assign mif.mem_ack   = t_ack;
    assign mif.mem_rdata = t_rdata;

    fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .reset     (t_reset),
        .mem       (mif),
        .stall     (t_stall),
        .br_taken  (t_br),
        .br_target (t_tgt),
        .ir_en     (ir_en),
        .ir_data   (ir_data),
        .pc        (pc),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic a, input logic s, input logic b,
                         input logic [AW-1:0] t, input logic [IW-1:0] d);
        t_reset = r; t_ack = a; t_stall = s; t_br = b; t_tgt = t; t_rdata = d;
        #1;
    endtask

    // Advance one clock and apply the fetch/issue rules to the model.
    task automatic tick();
        @(posedge clk);
        if (t_reset) begin
            m_holding = 1'b0; m_pc = RESET_PC; m_ibuf = '0; m_cnt = 0;
        end else if (t_br) begin
            m_pc = int'(t_tgt); m_holding = 1'b0;
        end else if (!m_holding) begin
            if (t_ack) begin
                m_ibuf = t_rdata; m_pc = (m_pc + 1) % (1 << AW); m_holding = 1'b1;
            end
        end else if (!t_stall) begin
            m_cnt = (m_cnt + 1) % 65536; m_holding = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, '0, '0);
        tick();
        drive(0, 0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, '0, 16'h5555);
        tick();
        tick();
        n_vec++;
        if (mif.mem_req !== 1'b0 || ir_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gate: mem_req=%b ir_en=%b required 0 0", mif.mem_req, ir_en);
        end
        drive(0, 0, 0, 0, '0, '0);
        n_vec++;
        if (mif.mem_req !== 1'b1 || mif.mem_addr !== AW'(RESET_PC) || icount !== 16'd0 || ir_data !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: req=%b addr=%h icount=%0d ir_data=%h required 1 %h 0 0000",
                     mif.mem_req, mif.mem_addr, icount, ir_data, AW'(RESET_PC));
        end
    endtask

    task automatic test_stream();
        logic [IW-1:0] exp_words [3] = '{16'h1000, 16'h1001, 16'h1002};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, '0, 16'h1000 + IW'(mif.mem_addr));
            n_vec++;
            if (ir_en !== 1'b0 || mif.mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL stream_fetch[%0d]: ir_en=%b req=%b required 0 1", i, ir_en, mif.mem_req);
            end
            tick();
            drive(0, 1, 0, 0, '0, 16'hDEAD);
            n_vec++;
            if (ir_en !== 1'b1 || ir_data !== exp_words[i]) begin
                n_err++;
                $display("FAIL stream_issue[%0d]: ir_en=%b ir_data=%h required 1 %h", i, ir_en, ir_data, exp_words[i]);
            end
            tick();
        end
        n_vec++;
        if (icount !== 16'd3) begin
            n_err++;
            $display("FAIL stream_icount: got %0d required 3", icount);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [3] = '{8'hFE, 8'hFF, 8'h00};
        do_reset();
        drive(0, 0, 0, 1, 8'hFE, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, '0, 16'h2000);
            n_vec++;
            if (mif.mem_addr !== exp_addr[i] || mif.mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_addr[%0d]: addr=%h req=%b required %h 1", i, mif.mem_addr, mif.mem_req, exp_addr[i]);
            end
            tick();
            drive(0, 0, 0, 0, '0, '0);
            tick();
        end
    endtask

    task automatic test_stall();
        logic [15:0]   cnt0;
        logic [AW-1:0] pc0;
        do_reset();
        drive(0, 1, 0, 0, '0, 16'hABCD);
        tick();
        cnt0 = icount;
        pc0  = pc;
        for (int i = 0; i < 4; i++) begin
            // ack held high with no request outstanding must change nothing
            drive(0, 1, 1, 0, '0, 16'h9999);
            n_vec++;
            if (ir_en !== 1'b0 || ir_data !== 16'hABCD || pc !== pc0 || mif.mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: ir_en=%b ir_data=%h pc=%h req=%b required 0 abcd %h 0",
                         i, ir_en, ir_data, pc, mif.mem_req, pc0);
            end
            tick();
        end
        drive(0, 0, 0, 0, '0, '0);
        n_vec++;
        if (ir_en !== 1'b1 || ir_data !== 16'hABCD) begin
            n_err++;
            $display("FAIL stall_release: ir_en=%b ir_data=%h required 1 abcd", ir_en, ir_data);
        end
        tick();
        n_vec++;
        if (icount !== cnt0 + 16'd1 || ir_en !== 1'b0) begin
            n_err++;
            $display("FAIL stall_count: icount=%0d ir_en=%b required %0d 0", icount, ir_en, cnt0 + 16'd1);
        end
    endtask

    task automatic test_branch();
        logic [15:0] cnt0;
        logic [15:0] buf0;
        do_reset();
        cnt0 = icount;
        buf0 = ir_data;
        drive(0, 1, 0, 1, 8'h40, 16'h7777);
        n_vec++;
        if (ir_en !== 1'b0 || mif.mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL branch_ack_now: ir_en=%b req=%b required 0 1", ir_en, mif.mem_req);
        end
        tick();
        drive(0, 0, 0, 0, '0, '0);
        n_vec++;
        if (mif.mem_addr !== 8'h40 || mif.mem_req !== 1'b1 || icount !== cnt0 || ir_data !== buf0) begin
            n_err++;
            $display("FAIL branch_ack_next: addr=%h req=%b icount=%0d ir_data=%h required 40 1 %0d %h",
                     mif.mem_addr, mif.mem_req, icount, ir_data, cnt0, buf0);
        end
        // branch while an instruction waits to issue
        drive(0, 1, 0, 0, '0, 16'h4242);
        tick();
        drive(0, 0, 0, 1, 8'h80, '0);
        n_vec++;
        if (ir_en !== 1'b0) begin
            n_err++;
            $display("FAIL branch_issue_now: ir_en=%b required 0", ir_en);
        end
        tick();
        drive(0, 0, 0, 0, '0, '0);
        n_vec++;
        if (mif.mem_addr !== 8'h80 || mif.mem_req !== 1'b1 || icount !== cnt0 || ir_data !== 16'h4242) begin
            n_err++;
            $display("FAIL branch_issue_next: addr=%h req=%b icount=%0d ir_data=%h required 80 1 %0d 4242",
                     mif.mem_addr, mif.mem_req, icount, ir_data, cnt0);
        end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        drive(0, 1, 0, 0, '0, 16'h1111);
        tick();
        drive(0, 0, 0, 0, '0, '0);
        tick();
        drive(0, 1, 0, 0, '0, 16'h2222);
        tick();
        drive(1, 0, 1, 0, '0, '0);
        n_vec++;
        if (ir_en !== 1'b0 || mif.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_issue_now: ir_en=%b req=%b required 0 0", ir_en, mif.mem_req);
        end
        tick();
        drive(0, 0, 0, 0, '0, '0);
        n_vec++;
        if (mif.mem_addr !== AW'(RESET_PC) || mif.mem_req !== 1'b1 || icount !== 16'd0 || ir_data !== 16'd0) begin
            n_err++;
            $display("FAIL rst_issue_next: addr=%h req=%b icount=%0d ir_data=%h required %h 1 0 0000",
                     mif.mem_addr, mif.mem_req, icount, ir_data, AW'(RESET_PC));
        end
    endtask

    task automatic test_random();
        logic          r, a, s, b;
        logic          exp_req, exp_ir;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 31) == 0);
            a = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 7) == 0);
            drive(r, a, s, b, AW'($urandom), IW'($urandom));
            exp_req = !r && !m_holding;
            exp_ir  = !r && m_holding && !s && !b;
            n_vec++;
            if (mif.mem_req !== exp_req || ir_en !== exp_ir || mif.mem_addr !== AW'(m_pc) ||
                pc !== AW'(m_pc) || ir_data !== m_ibuf || icount !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL random[%0d]: req=%b ir_en=%b addr=%h ir_data=%h icount=%0d required %b %b %h %h %0d",
                         i, mif.mem_req, ir_en, mif.mem_addr, ir_data, icount,
                         exp_req, exp_ir, AW'(m_pc), m_ibuf, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_stall();
        test_branch();
        test_reset_in_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, 8, instruction address width in bits; SHALL be in the range 4..16.
REQ-002 Parameter IW, 16, instruction word width in bits.
REQ-003 Parameter RESET_PC, 0, PC value loaded at reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 mem_req  output  1  instruction memory read request.
REQ-007 mem_addr  output  AW  read address; equals pc.
REQ-008 mem_ack  input  1  memory has placed the word on mem_rdata this cycle.
REQ-009 mem_rdata  input  IW  instruction word; valid only while mem_ack=1.
REQ-010 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-011 br_taken  input  1  redirect request.
REQ-012 br_target  input  AW  redirect address.
REQ-013 ir_en  output  1  one-cycle load enable for the downstream instruction-register flops.
REQ-014 ir_data  output  IW  instruction presented with ir_en.
REQ-015 pc  output  AW  current fetch address.
REQ-016 icount  output  16  number of instructions issued, wrapping modulo 2^16.

Function
REQ-017 The FSM SHALL have exactly two states: FETCH and ISSUE.
REQ-018 In FETCH: mem_req=1 and ir_en=0.
REQ-019 In ISSUE: mem_req=0.
REQ-020 mem_ack SHALL be ignored whenever mem_req=0.
REQ-021 In FETCH with mem_ack=1 and br_taken=0, on the next edge: ibuf<=mem_rdata; pc<=pc+1 modulo 2^AW, wrapping 2^AW-1 to 0; state->ISSUE.
REQ-022 In FETCH with mem_ack=0 and br_taken=0: state, pc and ibuf SHALL hold.
REQ-023 In ISSUE with stall=0 and br_taken=0: ir_en=1 combinationally this cycle; on the next edge state->FETCH and icount<=icount+1.
REQ-024 In ISSUE with stall=1 and br_taken=0: ir_en=0; state, ibuf and pc SHALL hold.
REQ-025 ir_data SHALL equal ibuf at all times.
REQ-026 Minimum issue period: 2 cycles per instruction with zero-wait memory (ack in the first FETCH cycle).
REQ-027 br_taken=1 in either state SHALL override ack and stall: ir_en=0; on the next edge pc<=br_target, state->FETCH, ibuf unchanged, icount unchanged.
REQ-028 Priority: reset > br_taken > mem_ack/stall.
REQ-029 A branch during FETCH SHALL abandon the outstanding request; mem_addr changes on the next cycle with mem_req still 1.

Reset
REQ-030 While reset=1: mem_req=0 and ir_en=0, gated combinationally.
REQ-031 On a reset edge: state<=FETCH, pc<=RESET_PC, ibuf<=0, icount<=0.
REQ-032 Reset asserted mid-fetch or mid-stall SHALL discard all in-flight data; the first request after reset SHALL be to RESET_PC.

Structure
REQ-033 Package fetch_pkg SHALL hold the state encoding (FETCH=1'b0, ISSUE=1'b1) and the defaults for AW, IW and RESET_PC.
REQ-034 Sub-module pc_reg SHALL be the AW-bit PC register (synchronous reset to RESET_PC; load has priority over increment).
REQ-035 All other logic SHALL be implemented in fetch_unit; the only registered state is state, ibuf, icount and the register inside pc_reg.

Verification
REQ-036 Reset, then mem_ack=1 each FETCH cycle with rdata=0x1000+addr -> ir_en pulses every 2nd cycle, ir_data 0x1000,0x1001,0x1002, icount=3.
REQ-037 AW=8, branch to 0xFE, 3 fetches -> mem_addr 0xFE,0xFF,0x00 (wrap).
REQ-038 stall=1 for 4 cycles in ISSUE with ibuf=0xABCD -> ir_en low 4 cycles, ir_data held 0xABCD, then one ir_en pulse, icount+1.
REQ-039 br_taken=1 with br_target=0x40 in the same cycle as mem_ack=1 -> no ir_en, next mem_addr=0x40, icount unchanged.
REQ-040 reset=1 during ISSUE with stall=1 -> ir_en=0 that cycle, next mem_addr=RESET_PC, icount=0.
REQ-041 mem_ack held high with mem_req=0 (ISSUE, stall=1) -> pc and ibuf unchanged.
